// File: rtl/cci_mpf_csr_event_counters.sv
// Event counter endpoint of the MPF CSR interface.
// Single-cycle event pulses from the shims are registered once, then accumulated into
// per-event wrapping counters with sticky wrap flags and per-counter clear. A fully
// pipelined read port returns a zero-extended counter value one cycle after each request.
module cci_mpf_csr_event_counters #(
    parameter int N_EVENTS  = 13,
    parameter int CNT_WIDTH = 48,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_EVENTS-1:0]  evt_in,
    input  logic [N_EVENTS-1:0]  clr_mask,
    input  logic                 rd_req,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic                 rd_rsp_valid,
    output logic [IDX_WIDTH-1:0] rd_rsp_idx,
    output logic [63:0]          rd_rsp_data,
    output logic [N_EVENTS-1:0]  ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Zero-extend a counter value onto the 64-bit CSR data bus.
    function automatic logic [63:0] zext_cnt(input logic [CNT_WIDTH-1:0] v);
        logic [63:0] r;
        r                = 64'd0;
        r[CNT_WIDTH-1:0] = v;
        return r;
    endfunction

    logic [N_EVENTS-1:0]  evt_q;
    logic [CNT_WIDTH-1:0] cnt_q [N_EVENTS];
    logic [CNT_WIDTH-1:0] cnt_d [N_EVENTS];
    logic [N_EVENTS-1:0]  ovf_q;
    logic [N_EVENTS-1:0]  ovf_d;
    logic                 rsp_valid_q;
    logic [IDX_WIDTH-1:0] rsp_idx_q;
    logic [63:0]          rsp_data_q;
    logic [63:0]          rd_data_s;

    // Counter next state: a clear beats an event sitting in the stage-1 register.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (clr_mask[i]) begin
                cnt_d[i] = {CNT_WIDTH{1'b0}};
                ovf_d[i] = 1'b0;
            end else if (evt_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
                ovf_d[i] = (cnt_q[i] == CNT_ONES) ? 1'b1 : ovf_q[i];
            end else begin
                cnt_d[i] = cnt_q[i];
                ovf_d[i] = ovf_q[i];
            end
        end
    end

    // Read mux over the pre-update counter values; out-of-range indices read as zero.
    always_comb begin
        rd_data_s = 64'd0;
        for (int i = 0; i < N_EVENTS; i++) begin
            rd_data_s = (rd_idx == IDX_WIDTH'(i)) ? zext_cnt(cnt_q[i]) : rd_data_s;
        end
    end

    // Stage-1 event capture and stage-2 counter/wrap-flag state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= {N_EVENTS{1'b0}};
            ovf_q <= {N_EVENTS{1'b0}};
            for (int i = 0; i < N_EVENTS; i++) begin
                cnt_q[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            evt_q <= evt_in;
            ovf_q <= ovf_d;
            for (int i = 0; i < N_EVENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read response pipeline: valid pulses per request, data/index hold between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= {IDX_WIDTH{1'b0}};
            rsp_data_q  <= 64'd0;
        end else begin
            rsp_valid_q <= rd_req;
            if (rd_req) begin
                rsp_idx_q  <= rd_idx;
                rsp_data_q <= rd_data_s;
            end else begin
                rsp_idx_q  <= rsp_idx_q;
                rsp_data_q <= rsp_data_q;
            end
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_idx   = rsp_idx_q;
    assign rd_rsp_data  = rsp_data_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Scoreboard bench: a 48-bit and an 8-bit counter instance share all stimulus. The driver
// keeps a per-event count model (modulo arithmetic) and queues expected read responses;
// a monitor pops and compares whenever the instances present a response.
module tb_cci_mpf_csr_event_counters;

    localparam int N  = 13;
    localparam int IW = 4;
    localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint unsigned MASK8  = 64'h0000_0000_0000_00FF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  evt_in = {N{1'b1}};
    logic [N-1:0]  clr_mask = '0;
    logic          rd_req = 1'b0;
    logic [IW-1:0] rd_idx = '0;

    logic          a_valid, b_valid;
    logic [IW-1:0] a_idx, b_idx;
    logic [63:0]   a_data, b_data;
    logic [N-1:0]  a_ovf, b_ovf;

    cci_mpf_csr_event_counters #(.N_EVENTS(N), .CNT_WIDTH(48), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .clr_mask(clr_mask),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_rsp_valid(a_valid), .rd_rsp_idx(a_idx),
        .rd_rsp_data(a_data), .ovf(a_ovf));

    cci_mpf_csr_event_counters #(.N_EVENTS(N), .CNT_WIDTH(8), .IDX_WIDTH(IW)) dut8 (
        .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .clr_mask(clr_mask),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_rsp_valid(b_valid), .rd_rsp_idx(b_idx),
        .rd_rsp_data(b_data), .ovf(b_ovf));

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [63:0]   d48;
        logic [63:0]   d8;
        int            t;
    } exp_t;

    exp_t            sb_q[$];
    longint unsigned m_cnt48 [N];
    longint unsigned m_cnt8  [N];
    logic [N-1:0]    m_evtq;
    logic [N-1:0]    m_ovf48;
    logic [N-1:0]    m_ovf8;
    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt48[i] = 0;
            m_cnt8[i]  = 0;
        end
        m_evtq  = '0;
        m_ovf48 = '0;
        m_ovf8  = '0;
        sb_q.delete();
    endtask

    // One clock of stimulus; the model is advanced to the state after the coming edge.
    task automatic step(input logic [N-1:0] evt, input logic [N-1:0] clr,
                        input logic req, input logic [IW-1:0] idx);
        exp_t e;
        @(negedge clk);
        evt_in   = evt;
        clr_mask = clr;
        rd_req   = req;
        rd_idx   = idx;
        if (req) begin
            e.idx = idx;
            e.d48 = (int'(idx) < N) ? m_cnt48[int'(idx)] : 64'd0;
            e.d8  = (int'(idx) < N) ? m_cnt8[int'(idx)]  : 64'd0;
            e.t   = cyc + 1;
            sb_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            if (clr[i]) begin
                m_cnt48[i] = 0;
                m_cnt8[i]  = 0;
                m_ovf48[i] = 1'b0;
                m_ovf8[i]  = 1'b0;
            end else if (m_evtq[i]) begin
                if (m_cnt48[i] == MASK48) m_ovf48[i] = 1'b1;
                if (m_cnt8[i] == MASK8)   m_ovf8[i]  = 1'b1;
                m_cnt48[i] = (m_cnt48[i] + 1) & MASK48;
                m_cnt8[i]  = (m_cnt8[i] + 1) & MASK8;
            end
        end
        m_evtq = evt;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0);
    endtask

    task automatic read_all();
        for (int k = 0; k < 16; k++) step('0, '0, 1'b1, IW'(k));
    endtask

    // Reset with all events asserted; released at a negedge together with evt_in cleared.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        evt_in  = '1;
        rd_req  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        evt_in  = '0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares responses against the scoreboard and wrap flags against the model.
    logic [IW-1:0] last_idx = '0;
    logic [63:0]   last_d48 = '0;
    logic [63:0]   last_d8  = '0;
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!reset_n) begin
            chk("valid48_in_reset", {63'd0, a_valid}, 64'd0);
            chk("valid8_in_reset", {63'd0, b_valid}, 64'd0);
            last_idx = '0;
            last_d48 = '0;
            last_d8  = '0;
        end else if (a_valid || b_valid) begin
            chk("valid_match", {63'd0, a_valid}, {63'd0, b_valid});
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp at cycle %0d: got valid 1 expected no response", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_latency", 64'(cyc), 64'(e.t));
                chk("rsp_idx48", {60'd0, a_idx}, {60'd0, e.idx});
                chk("rsp_idx8", {60'd0, b_idx}, {60'd0, e.idx});
                chk("rsp_data48", a_data, e.d48);
                chk("rsp_data8", b_data, e.d8);
                last_idx = e.idx;
                last_d48 = e.d48;
                last_d8  = e.d8;
            end
        end else begin
            chk("hold_idx", {60'd0, a_idx}, {60'd0, last_idx});
            chk("hold_data48", a_data, last_d48);
            chk("hold_data8", b_data, last_d8);
        end
        chk("ovf48", 64'(a_ovf), 64'(m_ovf48));
        chk("ovf8", 64'(b_ovf), 64'(m_ovf8));
    end

    logic [N-1:0] b3;
    logic [N-1:0] b2;
    logic [N-1:0] b0;
    logic [N-1:0] rnd_evt;
    logic [N-1:0] rnd_clr;

    initial begin
        b3 = N'(1) << 3;
        b2 = N'(1) << 2;
        b0 = N'(1);
        model_reset();
        // Reset with events asserted, then everything reads zero.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        evt_in  = '0;
        idle(2);
        read_all();
        idle(2);

        // Counting: five separated pulses then ten held cycles on event 3.
        for (int k = 0; k < 5; k++) begin
            step(b3, '0, 1'b0, '0);
            idle(1);
        end
        for (int k = 0; k < 10; k++) step(b3, '0, 1'b0, '0);
        idle(1);
        step('0, '0, 1'b1, 4'd3);
        read_all();
        idle(2);

        // Clear race on event 2: seven counted, eighth in stage 1, new pulse with the clear.
        step('0, b2, 1'b0, '0);
        for (int k = 0; k < 8; k++) step(b2, '0, 1'b0, '0);
        step('0, '0, 1'b1, 4'd2);
        step(b2, b2, 1'b0, '0);
        idle(2);
        step('0, '0, 1'b1, 4'd2);
        idle(2);

        // Wrap on event 0: 257 events wrap the 8-bit instance to 1 and set its flag.
        step('0, b0, 1'b0, '0);
        for (int k = 0; k < 257; k++) step(b0, '0, 1'b0, '0);
        idle(2);
        step('0, '0, 1'b1, 4'd0);
        step('0, b0, 1'b0, '0);
        idle(1);
        step('0, '0, 1'b1, 4'd0);

        // Back-to-back reads including an out-of-range index.
        for (int k = 0; k < 4; k++) step(b3 | b2, '0, 1'b0, '0);
        step('0, '0, 1'b1, 4'd0);
        step('0, '0, 1'b1, 4'd1);
        step('0, '0, 1'b1, 4'd2);
        step('0, '0, 1'b1, 4'd15);
        idle(2);

        // Reset arriving between a request and its response drops the response.
        for (int k = 0; k < 3; k++) step('1, '0, 1'b0, '0);
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = 4'd3;
        evt_in = '0;
        #2;
        reset_n = 1'b0;
        rd_req  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        read_all();

        // Randomized traffic with occasional clears and mid-run resets.
        for (int k = 0; k < 1500; k++) begin
            rnd_evt = N'($urandom);
            rnd_clr = ($urandom_range(0, 39) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
            step(rnd_evt, rnd_clr, 1'($urandom_range(0, 1)), IW'($urandom_range(0, 15)));
            if (k == 700) do_reset();
        end
        idle(3);
        read_all();
        idle(3);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rsp: got %0d outstanding expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
